db_event_arb: RTL and testbench
===============================

# db_event_arb

Debounces NCH mechanical switch inputs against one shared tick prescaler and turns every debounced edge into a press/release event. Events from all channels are arbitrated round-robin onto a single valid/ready event port. The block sits between the board switch pins and the control logic that consumes user-input events, and it replaces per-switch debouncers, each of which carried its own free-running counter.

## Interface
- NCH, default 4: number of switch channels (2..16).
- TICK_W, default 19: prescaler width. The debounce tick period is 2^TICK_W clk cycles.
- CH_W, default $clog2(NCH): width of evt_ch. Derived; do not override.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high. One clock; rst is sampled on the rising edge of clk.
- sw  in  NCH  raw switch levels.
- db  out  NCH  debounced stable levels, registered.
- evt_valid  out  1  an event is presented.
- evt_ready  in  1  the consumer accepts the event.
- evt_ch  out  CH_W  channel index of the presented event.
- evt_press  out  1  1 = rising debounced edge (press), 0 = falling (release).
- lost  out  1  sticky flag: an event was overwritten before delivery.

## Operation
- Prescaler q (TICK_W bits) free-runs. tick = (q == 2^TICK_W-1).
- Per channel, state is {db[i], cnt[i] (2 bits)}. cnt=0 means idle; cnt=1..3 are wait states.
  - Idle with s!=db: cnt<=1, where s is the (optionally synchronized) input.
  - Waiting with s==db: cnt<=0, abort. This applies regardless of tick.
  - Waiting with s!=db and tick: if cnt<3, cnt<=cnt+1. If cnt==3, db<=~db, cnt<=0, and an event is raised.
  - A debounced change therefore needs s to differ continuously from db across 3 ticks after entry.
- Event raise on channel i: pend[i]<=1 and kind[i]<=new db. If pend[i] was already 1, kind is overwritten and lost<=1.
- Output register {evt_valid, evt_ch, evt_press}:
  - Load condition: (!evt_valid || evt_ready) and any pend bit is set.
  - On load, select the first pending channel scanning rr, rr+1, …, wrapping modulo NCH. Load its kind, clear its pend, and set rr<=selected+1 mod NCH.
  - Handshake (evt_valid && evt_ready) with nothing pending: evt_valid<=0.
  - While evt_valid=1 and evt_ready=0, evt_ch and evt_press hold stable.
- If a raise and a load hit the same channel in the same cycle, the set wins: the old kind is loaded and pend stays 1 with the new kind. lost is not set.
- Reset values: q=0, cnt=0, db=0, pend=0, kind=0, rr=0, evt_valid=0, evt_ch=0, evt_press=0, lost=0, synchronizer flops=0. lost clears only on rst.

## Timing
- With TICK_W=3, the first tick occurs 7 cycles after rst deasserts, then every 8 cycles.
- db[i] changes on the clock edge of the third tick accepted in wait states.
- evt_valid rises 1 cycle after db[i] changes, if the output register is free.
- Throughput is one event per cycle while evt_ready=1.
- rst asserted mid-debounce or mid-handshake discards all state. No event is produced for an in-progress debounce.
- Input-to-state latency is 0 cycles without synchronization and 2 cycles with it (see Configuration).

## Configuration
- DB_SYNC_EN defined: each sw bit passes through a two-flop synchronizer (reset 0), and s is the second flop. All sw-relative timings shift by +2 cycles.
- DB_SYNC_EN undefined: s = sw directly. The caller guarantees sw is already synchronous to clk.

## Test plan
Unless stated otherwise: NCH=4, TICK_W=3, DB_SYNC_EN undefined, evt_ready=1.
- sw[0] goes to 1 in the first cycle after reset and holds.
  - cnt[0]=1 after that edge; ticks fall at cycles 7, 15 and 23.
  - db[0]=1 after cycle 23; the next cycle shows evt_valid=1, evt_ch=0, evt_press=1 for exactly one cycle.
- sw[1] toggles 1 for 5 cycles and 0 for 1 cycle, repeated for 100 cycles.
  - db[1] stays 0 and evt_valid never asserts.
- sw[3:0] rises simultaneously and holds.
  - db becomes 4'hF on one edge.
  - Events for ch 0, 1, 2, 3 appear in 4 consecutive cycles with evt_press=1; then evt_valid=0.
- Fairness: after an event on ch1 is delivered, ch0 and ch2 become pending in the same cycle.
  - ch2 is delivered first, then ch0.
- Backpressure with evt_ready=0: ch2 press, then release, then press, each fully debounced.
  - evt_ch=2, evt_press=1 holds stable throughout, and lost=1 after the second press.
  - After evt_ready=1: ch2 press delivered, then ch2 press again, then evt_valid=0.
- Reset and DB_SYNC_EN:
  - Pulse rst while ch0 is at cnt=2: db=0, evt_valid=0, lost=0, and no event follows for that debounce. sw[0] still held must restart the 3-tick debounce from entry.
  - With DB_SYNC_EN defined, repeat the first scenario: cnt[0]=1 occurs 2 cycles later, and db[0] still changes at cycle 23.

Source files
------------

// File: rtl/db_event_arb.sv
// Debounces NCH switch inputs against one shared tick prescaler and arbitrates the
// resulting press/release events round-robin onto one valid/ready port. Optional macro: DB_SYNC_EN.
module db_event_arb #(
    parameter int NCH    = 4,
    parameter int TICK_W = 19,
    parameter int CH_W   = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  sw,
    output logic [NCH-1:0]  db,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_press,
    output logic            lost
);

    localparam logic [1:0]      CNT_IDLE  = 2'd0;
    localparam logic [1:0]      CNT_FIRST = 2'd1;
    localparam logic [1:0]      CNT_LAST  = 2'd3;
    localparam logic [CH_W:0]   NCH_EXT   = (CH_W+1)'(NCH);
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NCH-1);

    logic [TICK_W-1:0] q;
    logic              tick;
    logic [NCH-1:0]    s;
    logic [1:0]        cnt [NCH];
    logic [NCH-1:0]    raise;
    logic [NCH-1:0]    pend;
    logic [NCH-1:0]    kind;
    logic [CH_W-1:0]   rr;
    logic [CH_W-1:0]   sel;
    logic              found;
    logic              load;
    logic [CH_W:0]     idx;

`ifdef DB_SYNC_EN
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = sw;
`endif

    assign tick = &q;

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= q + 1'b1;
    end

    // A channel raises an event on the third accepted tick while still differing.
    always_comb begin
        raise = '0;
        for (int i = 0; i < NCH; i++) begin
            raise[i] = (cnt[i] == CNT_LAST) && (s[i] != db[i]) && tick;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= CNT_IDLE;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cnt[i] == CNT_IDLE) begin
                    if (s[i] != db[i]) cnt[i] <= CNT_FIRST;
                end else if (s[i] == db[i]) begin
                    cnt[i] <= CNT_IDLE;
                end else if (tick) begin
                    if (cnt[i] == CNT_LAST) begin
                        db[i]  <= ~db[i];
                        cnt[i] <= CNT_IDLE;
                    end else begin
                        cnt[i] <= cnt[i] + 2'd1;
                    end
                end
            end
        end
    end

    // First pending channel at or after rr, wrapping modulo NCH.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = {1'b0, rr} + (CH_W+1)'(k);
            if (idx >= NCH_EXT) idx = idx - NCH_EXT;
            if (!found && pend[idx[CH_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[CH_W-1:0];
            end
        end
    end

    assign load = (!evt_valid || evt_ready) && (|pend);

    // A raise landing on the channel being loaded keeps it pending with the new kind.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            kind <= '0;
            lost <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (raise[i]) begin
                    pend[i] <= 1'b1;
                    kind[i] <= ~db[i];
                    if (pend[i] && !(load && sel == CH_W'(i))) lost <= 1'b1;
                end else if (load && sel == CH_W'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // evt_valid/evt_ch/evt_press follow valid/ready: the payload holds while valid && !ready,
    // and a transfer happens on any edge where valid && ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_press <= 1'b0;
            rr        <= '0;
        end else if (load) begin
            evt_valid <= 1'b1;
            evt_ch    <= sel;
            evt_press <= kind[sel];
            rr        <= (sel == CH_LAST) ? '0 : sel + 1'b1;
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_db_event_arb.sv
// Bench for db_event_arb: directed scenarios with literal expectations plus randomized
// switch activity compared every cycle against a cycle-count based reference model.
module tb_db_event_arb;

    localparam int NCH    = 4;
    localparam int TICK_W = 3;
    localparam int CH_W   = 2;
    localparam int PERIOD = 1 << TICK_W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  sw = '0;
    logic            evt_ready = 1'b1;
    logic [NCH-1:0]  db;
    logic            evt_valid;
    logic [CH_W-1:0] evt_ch;
    logic            evt_press;
    logic            lost;

    always #5 clk = ~clk;

    db_event_arb #(.NCH(NCH), .TICK_W(TICK_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .db        (db),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_press (evt_press),
        .lost      (lost)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a channel flips once the input has differed from the stable
    // level continuously since its entry cycle and the third tick after entry arrives.
    logic [NCH-1:0] m_db, m_pend, m_kind, m_s;
    bit             m_act [NCH];
    int             m_ent [NCH];
    int             m_t;
    logic           m_valid, m_press, m_lost;
    int             m_ch, m_rr, m_sel;
    bit             m_found;
`ifdef DB_SYNC_EN
    logic [NCH-1:0] m_y1, m_y2;
`endif

    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / PERIOD - a / PERIOD;
    endfunction

    function automatic bit is_tick(input int t);
        return ((t + 1) % PERIOD) == 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_db = '0; m_pend = '0; m_kind = '0; m_s = '0;
            m_t = 0; m_valid = 1'b0; m_press = 1'b0; m_lost = 1'b0;
            m_ch = 0; m_rr = 0;
            for (int i = 0; i < NCH; i++) begin
                m_act[i] = 1'b0;
                m_ent[i] = 0;
            end
`ifdef DB_SYNC_EN
            m_y1 = '0; m_y2 = '0;
`endif
        end else begin
`ifdef DB_SYNC_EN
            m_s = m_y2; m_y2 = m_y1; m_y1 = sw;
`else
            m_s = sw;
`endif
            if ((!m_valid || evt_ready) && (m_pend != '0)) begin
                m_found = 1'b0;
                m_sel = 0;
                for (int k = 0; k < NCH; k++) begin
                    if (!m_found && m_pend[(m_rr + k) % NCH]) begin
                        m_found = 1'b1;
                        m_sel = (m_rr + k) % NCH;
                    end
                end
                m_valid = 1'b1;
                m_ch = m_sel;
                m_press = m_kind[m_sel];
                m_pend[m_sel] = 1'b0;
                m_rr = (m_sel + 1) % NCH;
            end else if (m_valid && evt_ready) begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < NCH; i++) begin
                if (m_act[i]) begin
                    if (m_s[i] == m_db[i]) begin
                        m_act[i] = 1'b0;
                    end else if (is_tick(m_t) && ticks_in(m_ent[i] + 1, m_t) == 3) begin
                        m_db[i] = ~m_db[i];
                        m_act[i] = 1'b0;
                        if (m_pend[i]) m_lost = 1'b1;
                        m_pend[i] = 1'b1;
                        m_kind[i] = m_db[i];
                    end
                end else if (m_s[i] != m_db[i]) begin
                    m_act[i] = 1'b1;
                    m_ent[i] = m_t;
                end
            end
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("db", db, m_db);
            check("evt_valid", evt_valid, m_valid);
            if (m_valid) begin
                check("evt_ch", evt_ch, m_ch);
                check("evt_press", evt_press, m_press);
            end
            check("lost", lost, m_lost);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic wait_db(input int ch, input logic val, input int budget);
        int n = 0;
        while (db[ch] !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_db", db[ch], val);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (evt_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", evt_valid, 1'b1);
    endtask

    initial begin
        bit seen;
        int rate, rdy_pct;

        // Single channel press: ticks at cycles 7, 15, 23.
        do_reset();
        sw = 4'b0001;
        repeat (23) @(negedge clk);
        check("t1_db_before", db, 4'h0);
        @(negedge clk);
        check("t1_db_set", db, 4'h1);
        check("t1_valid_early", evt_valid, 1'b0);
        @(negedge clk);
        check("t1_valid", evt_valid, 1'b1);
        check("t1_ch", evt_ch, 0);
        check("t1_press", evt_press, 1'b1);
        @(negedge clk);
        check("t1_valid_drop", evt_valid, 1'b0);

        // Bouncing input never settles.
        do_reset();
        sw = '0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            sw[1] = (c % 6) != 5;
            @(negedge clk);
            if (evt_valid) seen = 1'b1;
        end
        check("t2_db1", db[1], 1'b0);
        check("t2_no_event", seen, 1'b0);

        // All channels at once.
        do_reset();
        sw = 4'hF;
        repeat (24) @(negedge clk);
        check("t3_db", db, 4'hF);
        for (int k = 0; k < NCH; k++) begin
            @(negedge clk);
            check("t3_valid", evt_valid, 1'b1);
            check("t3_ch", evt_ch, k);
            check("t3_press", evt_press, 1'b1);
        end
        @(negedge clk);
        check("t3_idle", evt_valid, 1'b0);

        // Fairness: rr points past ch1, so ch2 goes before ch0.
        do_reset();
        sw = 4'b0010;
        wait_valid(40);
        check("t4_first_ch", evt_ch, 1);
        @(negedge clk);
        sw = 4'b0111;
        wait_valid(60);
        check("t4_ch2", evt_ch, 2);
        check("t4_ch2_press", evt_press, 1'b1);
        @(negedge clk);
        check("t4_ch0_valid", evt_valid, 1'b1);
        check("t4_ch0", evt_ch, 0);
        @(negedge clk);
        check("t4_idle", evt_valid, 1'b0);

        // Backpressure: press, release, press on ch2 with the port stalled.
        do_reset();
        evt_ready = 1'b0;
        sw = 4'b0100;
        wait_db(2, 1'b1, 40);
        sw = 4'b0000;
        wait_db(2, 1'b0, 60);
        check("t5_hold_ch", evt_ch, 2);
        check("t5_hold_press", evt_press, 1'b1);
        check("t5_lost_early", lost, 1'b0);
        sw = 4'b0100;
        wait_db(2, 1'b1, 60);
        check("t5_lost", lost, 1'b1);
        check("t5_hold_ch2", evt_ch, 2);
        check("t5_hold_press2", evt_press, 1'b1);
        evt_ready = 1'b1;
        @(negedge clk);
        check("t5_second_valid", evt_valid, 1'b1);
        check("t5_second_ch", evt_ch, 2);
        check("t5_second_press", evt_press, 1'b1);
        @(negedge clk);
        check("t5_drained", evt_valid, 1'b0);

        // Reset in the middle of a debounce discards it; held inputs restart from entry.
        sw = 4'b0101;
        repeat (12) @(negedge clk);
        do_reset();
        check("t6_db", db, 4'h0);
        check("t6_valid", evt_valid, 1'b0);
        check("t6_lost", lost, 1'b0);
        repeat (23) @(negedge clk);
        check("t6_db_before", db, 4'h0);
        @(negedge clk);
        check("t6_db_set", db, 4'b0101);
        @(negedge clk);
        check("t6_ev0", evt_ch, 0);
        check("t6_ev0_valid", evt_valid, 1'b1);
        @(negedge clk);
        check("t6_ev2", evt_ch, 2);
        @(negedge clk);
        check("t6_idle", evt_valid, 1'b0);

        // Randomized activity, slow and fast switching, light and heavy backpressure.
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            rate = (seg % 2 == 1) ? 8 : 40;
            rdy_pct = (seg < 3) ? 75 : 25;
            for (int c = 0; c < 500; c++) begin
                if (seg == 4 && c == 250) do_reset();
                for (int i = 0; i < NCH; i++) begin
                    if ($urandom_range(rate - 1) == 0) sw[i] = ~sw[i];
                end
                evt_ready = ($urandom_range(99) < rdy_pct);
                @(negedge clk);
            end
        end
        sw = '0;
        evt_ready = 1'b1;
        repeat (60) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
